ccip_c1_tx_mux: RTL

//  Merges N_REQ write requesters inside top_level_module onto the single CCI-P c1 (write) Tx channel in the pClk domain.

---
 rtl/ccip_mux_pkg.sv | 76 +++++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/ccip_c1_tx_mux.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ccip_mux_pkg.sv
// Shared CCI-P c1 channel types and constants for the requester muxes.
// The c1 header field set is a reduced, self-contained mirror of the platform definitions.
package ccip_mux_pkg;

    localparam int N_REQ_MIN     = 2;
    localparam int N_REQ_MAX     = 16;
    localparam int MDATA_TAG_LSB = 0;

    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRFENCE  = 4'h4
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    // Packed (multi-line) write responses are not counted; interrupts never are.
    function automatic logic isCountedRsp(input t_ccip_c1_RspMemHdr h);
        return ((h.resp_type == eRSP_WRLINE) || (h.resp_type == eRSP_WRFENCE)) &&
               (h.format == 1'b0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grantIdx
);

    // Priority search starting one past the last winner.
    always_comb begin
        int   idx;
        logic hit;
        logic found;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx         = (int'(ptr) + k) % N;
            hit         = en && !found && req[idx];
            grant[idx]  = hit;
            grantIdx    = hit ? IW'(idx) : grantIdx;
            found       = found | hit;
        end
    end

endmodule

// File: rtl/ccip_c1_tx_mux.sv
// Round-robin merge of N_REQ write requesters onto the CCI-P c1 Tx channel,
// with almost-full backpressure, an outstanding-write cap and tag-steered responses.
module ccip_c1_tx_mux
    import ccip_mux_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 128,
    localparam int IDX_W = $clog2(N_REQ),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                pClk,
    input  logic                                pReset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  t_ccip_c1_ReqMemHdr [N_REQ-1:0]      req_hdr,
    input  t_ccip_clData [N_REQ-1:0]            req_data,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic                                c1_almfull,
    input  t_if_ccip_c1_Rx                      c1_rx,
    output t_if_ccip_c1_Tx                      c1_tx,
    output logic [N_REQ-1:0]                    resp_valid,
    output t_ccip_c1_RspMemHdr                  resp_hdr,
    output logic [CNT_W-1:0]                    outstanding,
    output logic                                err_underflow
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic               almFull_r;
    logic [IDX_W-1:0]   rrPtr_r;
    logic [N_REQ-1:0]   grant_s;
    logic [IDX_W-1:0]   grantIdx_s;
    logic               issueEn_s;
    logic               transfer_s;
    logic               rspCounted_s;
    logic               rspTagOk_s;
    logic [IDX_W-1:0]   rspTag_s;
    t_ccip_c1_ReqMemHdr txHdr_s;
    t_ccip_c1_RspMemHdr rspHdrClr_s;

    // Holding ready low while in reset keeps requesters from seeing a phantom accept.
    assign issueEn_s  = !pReset && !almFull_r && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign req_ready  = grant_s;
    assign transfer_s = |(req_valid & grant_s);

    rr_arbiter #(.N(N_REQ)) uArb (
        .req      (req_valid),
        .en       (issueEn_s),
        .ptr      (rrPtr_r),
        .grant    (grant_s),
        .grantIdx (grantIdx_s)
    );

    // Tag insertion on the outgoing header and tag extraction on the response.
    always_comb begin
        txHdr_s = req_hdr[grantIdx_s];
        txHdr_s.mdata[MDATA_TAG_LSB +: IDX_W] = grantIdx_s;
        rspHdrClr_s = c1_rx.hdr;
        rspHdrClr_s.mdata[MDATA_TAG_LSB +: IDX_W] = '0;
        rspTag_s     = c1_rx.hdr.mdata[MDATA_TAG_LSB +: IDX_W];
        rspTagOk_s   = (int'(rspTag_s) < N_REQ);
        rspCounted_s = c1_rx.rspValid && isCountedRsp(c1_rx.hdr);
    end

    // Almost-full is sampled once; CCI-P tolerates the extra grant this allows.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            almFull_r <= 1'b0;
        end else begin
            almFull_r <= c1_almfull;
        end
    end

    // Output register for the c1 Tx channel and round-robin pointer update.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            c1_tx   <= '0;
            rrPtr_r <= IDX_W'(N_REQ - 1);
        end else begin
            c1_tx.valid <= transfer_s;
            if (transfer_s) begin
                c1_tx.hdr  <= txHdr_s;
                c1_tx.data <= req_data[grantIdx_s];
                rrPtr_r    <= grantIdx_s;
            end else begin
                rrPtr_r    <= rrPtr_r;
            end
        end
    end

    // In-flight counter with sticky underflow flag.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({transfer_s, rspCounted_s})
                2'b10: outstanding <= outstanding + CNT_W'(1'b1);
                2'b01: begin
                    if (outstanding == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        outstanding <= outstanding - CNT_W'(1'b1);
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Response demux: one-hot pulse to the tagged requester, header with tag cleared.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            resp_valid <= '0;
            resp_hdr   <= '0;
        end else begin
            resp_valid <= (rspCounted_s && rspTagOk_s) ? (ONE_HOT0 << rspTag_s) : '0;
            if (rspCounted_s) begin
                resp_hdr <= rspHdrClr_s;
            end else begin
                resp_hdr <= resp_hdr;
            end
        end
    end

endmodule
